// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - iterative AES-128 round-key generator emitting keys in reverse order

// AES forward S-box, one byte, purely combinational lookup
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];
endmodule

// Reverse-order AES-128 key schedule: optional forward expansion, then inverse walk
module aes_inv_key_sched #(
  parameter int NUM_ROUNDS  = 10,
  parameter bit EMIT_ROUND0 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         key_is_last_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_round_o,
  output logic         rk_last_o,
  output logic         done_o
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_sched supports AES-128 only: NUM_ROUNDS must be 10");
  end

  localparam logic [3:0] FIRST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_ROUND  = EMIT_ROUND0 ? 4'd0 : 4'd1;
  localparam logic [3:0] FWD_LAST    = FIRST_ROUND - 4'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [127:0]  r_key;
  logic [127:0]  w_key_nxt;
  // Forward step count while in FWD, current round index while in EMIT
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_done;
  logic          w_done_nxt;

  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [31:0]   w_p3;
  logic [31:0]   w_g_in;
  logic [31:0]   w_rot;
  logic [31:0]   w_sub;
  logic [3:0]    w_rcon_idx;
  logic [7:0]    w_rcon;
  logic [31:0]   w_g;
  logic [31:0]   w_n0, w_n1, w_n2, w_n3;
  logic [127:0]  w_fwd_key;
  logic [127:0]  w_inv_key;
  logic          w_last;

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon_lut = 8'h01;
      4'd1:    rcon_lut = 8'h02;
      4'd2:    rcon_lut = 8'h04;
      4'd3:    rcon_lut = 8'h08;
      4'd4:    rcon_lut = 8'h10;
      4'd5:    rcon_lut = 8'h20;
      4'd6:    rcon_lut = 8'h40;
      4'd7:    rcon_lut = 8'h80;
      4'd8:    rcon_lut = 8'h1b;
      4'd9:    rcon_lut = 8'h36;
      default: rcon_lut = 8'h00;
    endcase
  endfunction

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  // The inverse step needs G of the previous w3, which is recovered as w3 ^ w2,
  // so the single G datapath is fed w3 going forward and w3 ^ w2 going backward.
  assign w_p3       = w_w3 ^ w_w2;
  assign w_g_in     = (r_state == S_FWD) ? w_w3 : w_p3;
  assign w_rot      = {w_g_in[23:0], w_g_in[31:24]};
  assign w_rcon_idx = (r_state == S_FWD) ? r_cnt : (r_cnt - 4'd1);
  assign w_rcon     = rcon_lut(w_rcon_idx);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  assign w_g = w_sub ^ {w_rcon, 24'h000000};

  assign w_n0      = w_w0 ^ w_g;
  assign w_n1      = w_n0 ^ w_w1;
  assign w_n2      = w_n1 ^ w_w2;
  assign w_n3      = w_n2 ^ w_w3;
  assign w_fwd_key = {w_n0, w_n1, w_n2, w_n3};

  assign w_inv_key = {w_w0 ^ w_g, w_w1 ^ w_w0, w_w2 ^ w_w1, w_p3};

  assign w_last = (r_cnt == LAST_ROUND);

  // Next-state, datapath next values and registered-state-derived outputs
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    busy_o      = (r_state != S_IDLE);
    rk_valid_o  = 1'b0;
    rk_o        = '0;
    rk_round_o  = '0;
    rk_last_o   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_key_nxt = key_i;
          if (key_is_last_i) begin
            w_state_nxt = S_EMIT;
            w_cnt_nxt   = FIRST_ROUND;
          end else begin
            w_state_nxt = S_FWD;
            w_cnt_nxt   = 4'd0;
          end
        end
      end

      S_FWD: begin
        w_key_nxt = w_fwd_key;
        if (r_cnt == FWD_LAST) begin
          w_state_nxt = S_EMIT;
          w_cnt_nxt   = FIRST_ROUND;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      S_EMIT: begin
        rk_valid_o = 1'b1;
        rk_o       = r_key;
        rk_round_o = r_cnt;
        rk_last_o  = w_last;
        if (rk_ready_i) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_key_nxt = w_inv_key;
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Key register, round counter and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_key  <= w_key_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign done_o = r_done;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - self-checking bench for aes_inv_key_sched
module tb_aes_inv_key_sched;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R9_A   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] R1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         key_is_last_i = 1'b0;
  logic         rk_ready_i = 1'b0;
  logic         busy_o, rk_valid_o, rk_last_o, done_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;

  logic         start0 = 1'b0;
  logic         ready0 = 1'b0;
  logic         busy0, rk_valid0, rk_last0, done0;
  logic [127:0] rk0;
  logic [3:0]   rk_round0;

  always #5 clk = ~clk;

  aes_inv_key_sched #(.NUM_ROUNDS(10), .EMIT_ROUND0(1'b1)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .key_i         (key_i),
    .key_is_last_i (key_is_last_i),
    .busy_o        (busy_o),
    .rk_valid_o    (rk_valid_o),
    .rk_ready_i    (rk_ready_i),
    .rk_o          (rk_o),
    .rk_round_o    (rk_round_o),
    .rk_last_o     (rk_last_o),
    .done_o        (done_o)
  );

  aes_inv_key_sched #(.NUM_ROUNDS(10), .EMIT_ROUND0(1'b0)) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start0),
    .key_i         (key_i),
    .key_is_last_i (key_is_last_i),
    .busy_o        (busy0),
    .rk_valid_o    (rk_valid0),
    .rk_ready_i    (ready0),
    .rk_o          (rk0),
    .rk_round_o    (rk_round0),
    .rk_last_o     (rk_last0),
    .done_o        (done0)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference model: S-box from GF(2^8) inversion plus affine map, FIPS-style word expansion
  logic [7:0]   sbox_m [0:255];
  logic [127:0] exp_rk [0:10];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[10-r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Scoreboard state for the EMIT_ROUND0=1 instance
  bit           chk_en = 1'b0;
  int           exp_idx = 0;
  int           hs_cnt = 0;
  bit           exp_done = 1'b0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_rk = '0;
  logic [3:0]   prev_round = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check(done_o == exp_done, "done_pulse", 128'(done_o), 128'(exp_done));
      if (prev_stall) check(rk_valid_o == 1'b1, "valid_held", 128'(rk_valid_o), 128'(1));
      if (rk_valid_o) begin
        if (exp_idx <= 10) begin
          check(rk_o == exp_rk[exp_idx], "rk_value", rk_o, exp_rk[exp_idx]);
          check(rk_round_o == 4'(10 - exp_idx), "rk_round", 128'(rk_round_o), 128'(10 - exp_idx));
          check(rk_last_o == (exp_idx == 10), "rk_last", 128'(rk_last_o), 128'(exp_idx == 10));
        end else begin
          check(exp_idx <= 10, "extra_beat", 128'(exp_idx), 128'(10));
        end
        if (prev_stall) begin
          check(rk_o == prev_rk, "stall_rk_hold", rk_o, prev_rk);
          check(rk_round_o == prev_round, "stall_round_hold", 128'(rk_round_o), 128'(prev_round));
        end
      end
      exp_done   = rk_valid_o && rk_ready_i && (exp_idx == 10);
      prev_stall = rk_valid_o && !rk_ready_i;
      prev_rk    = rk_o;
      prev_round = rk_round_o;
      if (rk_valid_o && rk_ready_i) begin
        exp_idx++;
        hs_cnt++;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({busy_o, rk_valid_o, rk_last_o, done_o} == 4'b0000, {name, "_flags"},
          128'({busy_o, rk_valid_o, rk_last_o, done_o}), 128'(0));
    check(rk_o == '0, {name, "_rk"}, rk_o, '0);
    check(rk_round_o == 4'd0, {name, "_round"}, 128'(rk_round_o), 128'(0));
  endtask

  // mode: 0 ready high, 1 random ready, 2 stray starts in FWD/EMIT,
  //       3 start on final handshake, 4 reset at the round-5 beat
  task automatic run_seq(input logic [127:0] k, input logic is_last, input int exp_lat,
                         input int mode, input string name);
    int lat;
    bit saw;
    exp_idx = 0;
    hs_cnt  = 0;
    chk_en  = 1'b1;
    key_i = k;
    key_is_last_i = is_last;
    rk_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      start_i = 1'b0;
      lat++;
      if (lat == 1) check(busy_o == 1'b1, {name, "_busy"}, 128'(busy_o), 128'(1));
      if (mode == 1) rk_ready_i = 1'($urandom_range(0, 1));
      if (mode == 2 && lat == 5) begin
        start_i = 1'b1;
        key_i = ~k;
        key_is_last_i = 1'b1;
      end
    end while (!rk_valid_o && lat < 40);
    check(lat == exp_lat, {name, "_latency"}, 128'(lat), 128'(exp_lat));
    saw = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_o) begin
        saw = 1'b1;
        break;
      end
      if (mode == 1) rk_ready_i = 1'($urandom_range(0, 1));
      if (mode == 2 && c == 3) begin
        start_i = 1'b1;
        key_i = ~k;
      end
      if (mode == 3 && rk_valid_o && rk_round_o == 4'd0) begin
        start_i = 1'b1;
        key_i = ~k;
        key_is_last_i = 1'b1;
      end
      if (mode == 4 && rk_valid_o && rk_round_o == 4'd5) begin
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero({name, "_async"});
        @(posedge clk); #1;
        check_all_zero({name, "_held"});
        rst_n = 1'b1;
        exp_done = 1'b0;
        prev_stall = 1'b0;
        chk_en = 1'b1;
        return;
      end
    end
    rk_ready_i = 1'b1;
    check(saw, {name, "_done_seen"}, 128'(saw), 128'(1));
    check(hs_cnt == 11, {name, "_handshakes"}, 128'(hs_cnt), 128'(11));
    check(busy_o == 1'b0 && rk_valid_o == 1'b0, {name, "_idle_after"},
          128'({busy_o, rk_valid_o}), 128'(0));
  endtask

  initial begin
    int  beats;
    bit  got_last;

    for (int i = 0; i < 256; i++) sbox_m[i] = sb_calc(8'(i));
    check(sbox_m[8'h00] == 8'h63, "model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
    check(sbox_m[8'h53] == 8'hed, "model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
    model_expand(R10_Z ^ R10_Z);
    check(exp_rk[0] == R10_Z, "model_zero_r10", exp_rk[0], R10_Z);
    model_expand(KEY_A);
    check(exp_rk[0] == R10_A, "model_a_r10", exp_rk[0], R10_A);
    check(exp_rk[1] == R9_A, "model_a_r9", exp_rk[1], R9_A);
    check(exp_rk[9] == R1_A, "model_a_r1", exp_rk[9], R1_A);
    check(exp_rk[10] == KEY_A, "model_a_r0", exp_rk[10], KEY_A);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check({busy0, rk_valid0, done0} == 3'b000, "reset_dut0", 128'({busy0, rk_valid0, done0}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(KEY_A, 1'b0, 11, 0, "cipher_key");
    repeat (2) @(posedge clk);
    #1;
    run_seq(R10_A, 1'b1, 1, 3, "last_key");
    model_expand(128'h0);
    check(exp_rk[10] == 128'h0, "model_zero_r0", exp_rk[10], 128'h0);
    run_seq(128'h0, 1'b0, 11, 0, "zero_key");
    repeat (2) @(posedge clk);
    #1;
    model_expand(KEY_A);
    run_seq(KEY_A, 1'b0, 11, 1, "rand_ready");
    repeat (2) @(posedge clk);
    #1;
    run_seq(KEY_A, 1'b0, 11, 2, "stray_start");
    repeat (2) @(posedge clk);
    #1;

    key_i = KEY_A;
    key_is_last_i = 1'b0;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    beats = 0;
    got_last = 1'b0;
    for (int c = 0; c < 60 && !got_last; c++) begin
      @(negedge clk);
      if (rk_valid0) begin
        if (beats < 10) begin
          check(rk0 == exp_rk[beats], "r0off_rk", rk0, exp_rk[beats]);
          check(rk_round0 == 4'(10 - beats), "r0off_round", 128'(rk_round0), 128'(10 - beats));
          check(rk_last0 == (beats == 9), "r0off_last", 128'(rk_last0), 128'(beats == 9));
        end
        beats++;
        if (rk_last0) got_last = 1'b1;
      end
    end
    check(got_last, "r0off_last_seen", 128'(got_last), 128'(1));
    check(beats == 10, "r0off_beats", 128'(beats), 128'(10));
    @(posedge clk); #1;
    check(done0 == 1'b1 && rk_valid0 == 1'b0 && busy0 == 1'b0, "r0off_done",
          128'({done0, rk_valid0, busy0}), 128'(3'b100));
    repeat (2) @(posedge clk);
    #1;

    run_seq(KEY_A, 1'b0, 11, 4, "mid_reset");
    run_seq(KEY_A, 1'b0, 11, 0, "after_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Iterative AES-128 round-key generator for the decryption datapath. It emits round keys in reverse order, round 10 down to round 0, one per valid/ready beat.
- It accepts either the cipher key or the round-10 key.
  - If given the cipher key, it first runs the forward expansion internally: 10 cycles, no output.
  - It then walks the schedule backwards using the inverse key-step.
- It sits between the key-load interface and the inverse-cipher round pipeline, so no 11-entry key store is needed.

Parameters:
- NUM_ROUNDS, 10: AES-128 round count. Any other value is an elaboration error.
- EMIT_ROUND0, 1: 1 emits rounds 10..0 (11 beats); 0 stops after round 1 (10 beats).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  load request; sampled only in IDLE
- key_i  in  128  cipher key or round-10 key; word0 = key_i[127:96]
- key_is_last_i  in  1  1: key_i is the round-10 key; 0: key_i is the cipher key
- busy_o  out  1  high in any state other than IDLE
- rk_valid_o  out  1  round key available
- rk_ready_i  in  1  consumer accepts rk_o
- rk_o  out  128  current round key, same word order as key_i
- rk_round_o  out  4  round index of rk_o (10..0)
- rk_last_o  out  1  marks the final beat
- done_o  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, key register 0, round counter 0.
- Word convention: w0..w3 = bits [127:96],[95:64],[63:32],[31:0].
- G(x) = SubWord(RotWord(x)) ^ {Rcon[r],24'h0}.
  - RotWord is a left rotate by one byte.
  - Rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36.
- Forward step, round r to r+1:
  - n0 = w0 ^ G(w3, r)
  - n1 = n0 ^ w1
  - n2 = n1 ^ w2
  - n3 = n2 ^ w3
- Inverse step, round r+1 to r:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ G(p3, r)
- Four S-box instances, combinational, shared by both steps. No other arithmetic; all operations are 32-bit XOR.
- FSM states: IDLE, FWD, EMIT.
- IDLE, on start_i=1:
  - Load key_i into the key register.
  - If key_is_last_i=1: go to EMIT with round=10. rk_valid_o rises the cycle after start.
  - If key_is_last_i=0: go to FWD with cnt=0.
- FWD:
  - Each cycle apply the forward step with r=cnt, then increment cnt.
  - After the cycle with cnt=9, go to EMIT with round=10.
  - rk_valid_o first rises 11 cycles after the start edge.
- EMIT:
  - rk_valid_o=1, rk_o=key register, rk_round_o=round.
  - rk_last_o=1 when round==0 (EMIT_ROUND0=1) or round==1 (EMIT_ROUND0=0).
  - On rk_valid_o & rk_ready_i and not last: apply the inverse step with r=round-1; decrement round.
  - On the last beat handshake: go to IDLE; done_o=1 for the next cycle only; rk_valid_o=0.
- Backpressure: while rk_valid_o & !rk_ready_i, rk_o, rk_round_o and rk_last_o hold stable. rk_valid_o never drops before the handshake.
- start_i outside IDLE is ignored. A new key is not queued.
- start_i on the same cycle as the final handshake is ignored. It may be reasserted the next cycle, when done_o=1 and state=IDLE.
- rk_ready_i high with no valid key has no effect.
- Reset asserted mid-FWD or mid-EMIT: immediate return to IDLE with all outputs 0. The partial sequence is discarded and no done_o is produced.
- Throughput: one round key per cycle with rk_ready_i held high.
- Key-to-first-key latency: 1 cycle (last-key load) or 11 cycles (cipher-key load).

Test Plan:
- FIPS-197 A.1 cipher key 2b7e151628aed2a6abf7158809cf4f3c, key_is_last_i=0, rk_ready_i=1:
  - rk_valid_o rises 11 cycles after start.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = input key, with rk_last_o=1.
  - done_o pulses once.
- Load d014f9a8c9ee2589e13f0cc8b6630ca6 with key_is_last_i=1:
  - rk_valid_o rises 1 cycle after start.
  - Identical 11-key sequence to the first scenario.
- All-zero cipher key:
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Round 0 = 0.
- Random rk_ready_i (about 50%) during the first scenario:
  - rk_o and rk_round_o stay stable while stalled.
  - Exactly 11 handshakes, rounds strictly 10..0.
- start_i pulsed during FWD and during EMIT with a different key: ignored, and the sequence is unchanged.
- EMIT_ROUND0=0: 10 beats, rk_last_o on round 1 = a0fafe17....
- rst_n low at the round-5 beat: outputs 0 immediately; a fresh start reproduces the full correct sequence.
